// File: rtl/fifo_uart_tx_pkg.sv
// Shared types for the FIFO-fed UART transmitter: FSM state encoding and frame constants.
// Latency: n/a (declarations only).
// Backpressure: n/a. FIFO_TX_PARITY_EN adds the even-parity helper.
package fifo_uart_tx_pkg;

  // Data bits per frame, sent LSB first.
  localparam int DATA_BITS = 8;

  // 3-bit state encoding; S_PARITY is only reachable when parity is built in.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RD_STROBE = 3'd1,
    S_START     = 3'd2,
    S_DATA      = 3'd3,
    S_PARITY    = 3'd4,
    S_STOP      = 3'd5
  } state_t;

`ifdef FIFO_TX_PARITY_EN
  // Even parity over one data byte: makes the count of ones, including the parity bit, even.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction
`endif

endpackage

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
// Baud tick generator: a one-cycle tick every BAUD_DIV clocks while clr is low.
// Latency: the first tick comes BAUD_DIV clocks after clr drops (count 0..BAUD_DIV-1).
// Backpressure: none. clr holds the count at 0 and suppresses the tick.
module baud_tick_gen #(
  parameter int BAUD_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = !clr && (cnt == LAST);

  // Free-running divider: wraps on tick and restarts when cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains fifo_interface one byte per active-low read strobe and sends each byte on txd as start, 8 data bits LSB first, optional parity, stop.
// Latency: RD_LOW_CYC strobe clocks, then 10*BAUD_DIV clocks per frame (11*BAUD_DIV with FIFO_TX_PARITY_EN); back-to-back while tx_en && nempty.
// Backpressure: tx_en and nempty are sampled only in IDLE and at the end of STOP. A started strobe or frame always completes.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int BAUD_DIV   = 16,
  parameter int RD_LOW_CYC = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_en,
  input  logic             nempty,
  input  logic [7:0]       out_data,
  output logic             fiford,
  output logic             txd,
  output logic             busy,
  output logic [CNT_W-1:0] tx_cnt
);

  localparam int RD_W = (RD_LOW_CYC > 2) ? $clog2(RD_LOW_CYC) : 1;
  localparam logic [RD_W-1:0] RD_LAST  = RD_W'(RD_LOW_CYC - 1);
  localparam logic [2:0]      LAST_BIT = 3'(DATA_BITS - 1);

  state_t          state;
  logic [RD_W-1:0] rd_cnt;
  logic [7:0]      shreg;
  logic [2:0]      bit_idx;
  logic            tick;
  logic            baud_clr;
`ifdef FIFO_TX_PARITY_EN
  logic            par;
`endif

  // Hold the divider at 0 until START begins, so START starts at a bit boundary.
  assign baud_clr = (state == S_IDLE) || (state == S_RD_STROBE);

  baud_tick_gen #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (baud_clr),
    .tick (tick)
  );

  // Transmit FSM. All outputs are registered, so txd changes exactly on bit boundaries.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      rd_cnt  <= '0;
      shreg   <= '0;
      bit_idx <= '0;
      fiford  <= 1'b1;
      txd     <= 1'b1;
      busy    <= 1'b0;
      tx_cnt  <= '0;
`ifdef FIFO_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (tx_en && nempty) begin
            state  <= S_RD_STROBE;
            fiford <= 1'b0;
            busy   <= 1'b1;
            rd_cnt <= '0;
          end
        end

        S_RD_STROBE: begin
          // Read data is valid by the last low cycle of the strobe. Capture it there.
          if (rd_cnt == RD_LAST) begin
            shreg  <= out_data;
`ifdef FIFO_TX_PARITY_EN
            par    <= even_parity(out_data);
`endif
            fiford <= 1'b1;
            txd    <= 1'b0;
            state  <= S_START;
          end else begin
            rd_cnt <= rd_cnt + 1'b1;
          end
        end

        S_START: begin
          if (tick) begin
            txd     <= shreg[0];
            bit_idx <= '0;
            state   <= S_DATA;
          end
        end

        S_DATA: begin
          if (tick) begin
            shreg <= {1'b0, shreg[7:1]};
            if (bit_idx == LAST_BIT) begin
`ifdef FIFO_TX_PARITY_EN
              txd   <= par;
              state <= S_PARITY;
`else
              txd   <= 1'b1;
              state <= S_STOP;
`endif
            end else begin
              txd     <= shreg[1];
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end

`ifdef FIFO_TX_PARITY_EN
        S_PARITY: begin
          if (tick) begin
            txd   <= 1'b1;
            state <= S_STOP;
          end
        end
`endif

        S_STOP: begin
          // The frame is complete here. Chain straight into the next read if data is waiting.
          if (tick) begin
            tx_cnt <= tx_cnt + 1'b1;
            if (tx_en && nempty) begin
              state  <= S_RD_STROBE;
              fiford <= 1'b0;
              rd_cnt <= '0;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
        end

        default: begin
          state  <= S_IDLE;
          fiford <= 1'b1;
          txd    <= 1'b1;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: a behavioural FIFO source plus a frame-level reference built from each byte.
// Latency: expected frame = RD_LOW_CYC strobe clocks, then one entry per serial bit, each held BAUD_DIV clocks.
// Backpressure: tx_en is toggled mid-frame and reset is applied mid-frame. Define FIFO_TX_PARITY_EN to check parity frames.
module tb_fifo_uart_tx;

  localparam int BAUD_DIV   = 4;
  localparam int RD_LOW_CYC = 4;
  localparam int CNT_W      = 16;
`ifdef FIFO_TX_PARITY_EN
  localparam int FRAME_LEN  = 11;
`else
  localparam int FRAME_LEN  = 10;
`endif
  localparam int BYTE_CLKS  = RD_LOW_CYC + FRAME_LEN * BAUD_DIV;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             tx_en = 1'b0;
  logic             nempty;
  logic [7:0]       out_data;
  logic             fiford;
  logic             txd;
  logic             busy;
  logic [CNT_W-1:0] tx_cnt;

  // Behavioural FIFO source: written by the stimulus, popped when the read strobe ends.
  logic [7:0] mem [0:255];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;
  logic       fiford_q = 1'b1;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  assign nempty   = (wr_ptr != rd_ptr);
  assign out_data = mem[rd_ptr];

  fifo_uart_tx #(
    .BAUD_DIV   (BAUD_DIV),
    .RD_LOW_CYC (RD_LOW_CYC),
    .CNT_W      (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_en    (tx_en),
    .nempty   (nempty),
    .out_data (out_data),
    .fiford   (fiford),
    .txd      (txd),
    .busy     (busy),
    .tx_cnt   (tx_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pop one entry on each rising edge of fiford, as the real FIFO does.
  always @(negedge clk) begin
    if (fiford && !fiford_q) rd_ptr <= rd_ptr + 8'd1;
    fiford_q <= fiford;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired: checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  // Check one complete strobe and frame against the waveform built from byte b.
  // drop_bit: drop tx_en at the start of that frame bit. abort_bit: return at the start of that bit.
  task automatic check_frame(input logic [7:0] b, input int drop_bit, input int abort_bit);
    logic [11:0] fb;
    int w;
    int low;
    fb = '1;
    fb[0] = 1'b0;
    for (int k = 0; k < 8; k++) fb[k+1] = b[k];
`ifdef FIFO_TX_PARITY_EN
    fb[9] = ^b;
`endif
    w = 0;
    while (fiford !== 1'b0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (fiford !== 1'b0) begin
      check("strobe_wait", {31'd0, fiford}, 32'd0);
      return;
    end
    low = 0;
    while (fiford === 1'b0 && low < 50) begin
      low++;
      @(negedge clk);
    end
    check("strobe_len", low, RD_LOW_CYC);
    for (int i = 0; i < FRAME_LEN; i++) begin
      for (int j = 0; j < BAUD_DIV; j++) begin
        if (i == abort_bit && j == 0) return;
        if (i == drop_bit && j == 0) tx_en = 1'b0;
        check($sformatf("txd_bit%0d_clk%0d", i, j), {31'd0, txd}, {31'd0, fb[i]});
        if (i == 1 && j == 0) check("busy_in_frame", {31'd0, busy}, 32'd1);
        if (j == 0) check("no_strobe_in_frame", {31'd0, fiford}, 32'd1);
        @(negedge clk);
      end
    end
  endtask

  initial begin
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] bytes [0:7];
    int t0;
    int t1;
    bit saw_low;

    // 1: reset state, then no strobe with an empty FIFO.
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_fiford", {31'd0, fiford}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_tx_cnt", {16'd0, tx_cnt}, 32'd0);
    rst = 1'b1;
    tx_en = 1'b1;
    saw_low = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (fiford === 1'b0) saw_low = 1'b1;
    end
    check("empty_no_strobe", {31'd0, saw_low}, 32'd0);

    // 2: single byte A5.
    push(8'hA5);
    check_frame(8'hA5, -1, -1);
    check("single_tx_cnt", {16'd0, tx_cnt}, 32'd1);
    check("single_busy_after", {31'd0, busy}, 32'd0);

    // 3: eight random bytes back-to-back.
    for (int k = 0; k < 8; k++) begin
      bytes[k] = 8'($urandom_range(0, 255));
      push(bytes[k]);
    end
    w_loop: for (int w = 0; w < 100; w++) begin
      if (fiford === 1'b0) break;
      @(negedge clk);
    end
    t0 = cyc;
    for (int k = 0; k < 8; k++) check_frame(bytes[k], -1, -1);
    t1 = cyc;
    check("burst_clocks", t1 - t0, 8 * BYTE_CLKS);
    check("burst_nempty", {31'd0, nempty}, 32'd0);
    check("burst_tx_cnt", {16'd0, tx_cnt}, 32'd9);
    check("burst_busy_after", {31'd0, busy}, 32'd0);

    // 4: drop tx_en during data bit 3; the frame finishes and no new read starts until re-enabled.
    for (int k = 0; k < 3; k++) begin
      bytes[k] = 8'($urandom_range(0, 255));
      push(bytes[k]);
    end
    check_frame(bytes[0], 4, -1);
    check("pause_busy", {31'd0, busy}, 32'd0);
    saw_low = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (fiford === 1'b0) saw_low = 1'b1;
    end
    check("pause_no_strobe", {31'd0, saw_low}, 32'd0);
    check("pause_nempty", {31'd0, nempty}, 32'd1);
    check("pause_tx_cnt", {16'd0, tx_cnt}, 32'd10);
    tx_en = 1'b1;
    check_frame(bytes[1], -1, -1);
    check_frame(bytes[2], -1, -1);
    check("resume_tx_cnt", {16'd0, tx_cnt}, 32'd12);

    // 5: reset mid-DATA while txd is low, then a clean frame after release.
    b0 = 8'($urandom_range(0, 255)) & 8'hFB;
    b1 = 8'($urandom_range(0, 255));
    push(b0);
    push(b1);
    check_frame(b0, -1, 3);
    check("pre_rst_txd", {31'd0, txd}, 32'd0);
    rst = 1'b0;
    #1;
    check("midrst_txd", {31'd0, txd}, 32'd1);
    check("midrst_fiford", {31'd0, fiford}, 32'd1);
    check("midrst_tx_cnt", {16'd0, tx_cnt}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check_frame(b1, -1, -1);
    check("post_rst_tx_cnt", {16'd0, tx_cnt}, 32'd1);

    // 6: byte 07 (parity bit 1 when parity is built in).
    push(8'h07);
    check_frame(8'h07, -1, -1);
    check("final_tx_cnt", {16'd0, tx_cnt}, 32'd2);
    check("final_busy", {31'd0, busy}, 32'd0);
    check("final_txd_idle", {31'd0, txd}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
